// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: MEM stage has priority, while a bounded-starvation
// counter guarantees that the VGA image reader gets a slot. Read data is
// returned one cycle after the grant, with a valid flag that identifies the owner.
module dmem_port_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 64,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_req,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_addr,
    input  logic [DW-1:0] pipe_wdata,
    output logic          pipe_gnt,
    output logic          pipe_stall,
    output logic          pipe_rvalid,
    output logic [DW-1:0] pipe_rdata,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stall_count
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam int unsigned CntW  = 16;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
    localparam logic [CntW-1:0]  CntMax  = '1;

    typedef enum logic {
        ST_PRIO,
        ST_FORCE
    } arbStateT;

    logic [WaitW-1:0] waitQ;
    logic [WaitW-1:0] waitD;
    arbStateT         arbState;
    logic             pipeRvalidQ;
    logic             vgaRvalidQ;
    logic [CntW-1:0]  stallCntQ;

    // Arbitration mode: the VGA request wins a conflict only when the wait counter is saturated
    always_comb begin
        arbState = ST_PRIO;
        if (waitQ == WaitMax) begin
            arbState = ST_FORCE;
        end
    end

    // Combinational grants; at most one requester wins per cycle
    always_comb begin
        vga_gnt    = 1'b0;
        pipe_gnt   = 1'b0;
        pipe_stall = 1'b0;
        vga_gnt    = vga_req & (~pipe_req | (arbState == ST_FORCE));
        pipe_gnt   = pipe_req & ~vga_gnt;
        pipe_stall = pipe_req & ~pipe_gnt;
    end

    // Next wait count: count denied VGA cycles, clear on grant or withdrawn request
    always_comb begin
        waitD = '0;
        if (vga_req && !vga_gnt) begin
            waitD = (waitQ == WaitMax) ? WaitMax : waitQ + WaitW'(1);
        end
    end

    // Memory port mux; all outputs are zero when no requester is granted
    always_comb begin
        mem_en    = pipe_gnt | vga_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (pipe_gnt) begin
            mem_we    = pipe_we;
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
        end else if (vga_gnt) begin
            mem_addr  = vga_addr;
        end
    end

    // Wait-counter state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitQ <= '0;
        end else begin
            waitQ <= waitD;
        end
    end

    // Owner-tagged read-return valids; a write grant returns no valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipeRvalidQ <= 1'b0;
            vgaRvalidQ  <= 1'b0;
        end else begin
            pipeRvalidQ <= pipe_gnt & ~pipe_we;
            vgaRvalidQ  <= vga_gnt;
        end
    end

    // Saturating count of pipeline stall cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCntQ <= '0;
        end else if (pipe_stall && (stallCntQ != CntMax)) begin
            stallCntQ <= stallCntQ + CntW'(1);
        end
    end

    assign pipe_rvalid = pipeRvalidQ;
    assign vga_rvalid  = vgaRvalidQ;
    assign pipe_rdata  = mem_rdata;
    assign vga_rdata   = mem_rdata;
    assign stall_count = stallCntQ;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single data-memory port between the pipeline MEM stage and the VGA image reader. The MEM stage has priority. A starvation counter guarantees the VGA fetch a slot within MAX_WAIT cycles. Read data is returned with a one-cycle, owner-tagged valid, and `pipe_stall` goes to the hazard unit whenever the MEM stage loses arbitration.

## Interface
Parameters:
- AW, 16, memory address width
- DW, 64, memory data width
- MAX_WAIT, 4, maximum consecutive cycles a pending VGA request may be denied (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- pipe_req  in  1  MEM-stage access request, held until granted
- pipe_we  in  1  1 = write, 0 = read
- pipe_addr  in  AW  MEM-stage address
- pipe_wdata  in  DW  MEM-stage write data
- pipe_gnt  out  1  MEM-stage access issued this cycle
- pipe_stall  out  1  pipe_req & ~pipe_gnt
- pipe_rvalid  out  1  pipe_rdata valid (read granted previous cycle)
- pipe_rdata  out  DW  read data to MEM stage
- vga_req  in  1  image-reader fetch request, held until granted
- vga_addr  in  AW  fetch address
- vga_gnt  out  1  fetch issued this cycle
- vga_rvalid  out  1  vga_rdata valid
- vga_rdata  out  DW  fetch data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  synchronous RAM read data, valid the cycle after mem_en & ~mem_we
- stall_count  out  16  saturating count of pipe_stall cycles

## Operation
- At most one grant per cycle. Grants are combinational from the requests and the registered `vga_wait`.
- Arbitration rule:
  - `vga_gnt = vga_req & (~pipe_req | vga_wait == MAX_WAIT)`
  - `pipe_gnt = pipe_req & ~vga_gnt`
- `vga_wait` (width clog2(MAX_WAIT+1)):
  - Increments, saturating at MAX_WAIT, on each cycle with vga_req & ~vga_gnt.
  - Clears on vga_gnt or ~vga_req.
- Memory drive:
  - `mem_en = pipe_gnt | vga_gnt`.
  - On pipe_gnt, drive pipe_we, pipe_addr and pipe_wdata.
  - On vga_gnt, drive we=0 and vga_addr; mem_wdata is don't-care, driven 0.
  - With no grant, all mem_* outputs are 0.
- VGA never writes.
- Read-return tag:
  - Registered `pipe_rvalid <= pipe_gnt & ~pipe_we`; registered `vga_rvalid <= vga_gnt`.
  - `pipe_rdata` and `vga_rdata` both equal mem_rdata combinationally; consumers qualify with rvalid.
- A pipe write returns no rvalid.
- stall_count increments on every cycle pipe_stall=1 and holds at 16'hFFFF.
- FSM view, conceptual state = vga_wait:
  - PRIO (wait<MAX_WAIT): pipe wins conflicts.
  - FORCE (wait==MAX_WAIT): VGA wins exactly one cycle, then returns to PRIO with wait=0.

## Timing
- Grant latency: 0 cycles, same cycle as req when the requester wins.
- Read latency: rvalid asserted exactly 1 cycle after the read grant, for 1 cycle.
- Continuous contention: VGA is granted on at most every (MAX_WAIT+1)th cycle; the pipe is stalled 1 cycle per VGA-forced grant.
- Same-cycle same-address conflict: pipe write granted first (wait<MAX_WAIT). The VGA read granted later returns the new data.
- vga_req dropped while waiting: wait clears the next cycle, no grant owed.
- Reset asserted (reset=0), any cycle:
  - vga_wait=0, pipe_rvalid=0, vga_rvalid=0, stall_count=0, immediately.
  - A read granted in the cycle before reset returns no rvalid.
  - The combinational grant/mem outputs still follow the inputs, since grants are combinational; the pipeline holds requests low during reset.
- After reset release, the first edge behaves as if from the idle state.

## Test plan
- Pipe read alone: pipe_req=1, we=0, addr=16'h0010, no vga_req -> pipe_gnt=1, mem_en=1, mem_addr=16'h0010 same cycle; pipe_rvalid=1 next cycle with pipe_rdata=mem_rdata; stall_count=0.
- VGA alone: vga_req=1, addr=16'h0200 -> vga_gnt=1 same cycle, mem_we=0; vga_rvalid=1 next cycle.
- Continuous contention, MAX_WAIT=4, pipe reads and vga_req both held:
  - pipe_gnt for 4 cycles, vga_gnt on the 5th cycle with pipe_stall=1 in that cycle.
  - Pattern repeats every 5 cycles; stall_count=2 after 10 cycles.
- Conflict write/read to 16'h0040: pipe writes 64'hDEADBEEF_00000001 while VGA reads the same address -> pipe_gnt first; the later VGA read returns 64'hDEADBEEF_00000001.
- Reset mid-read: pipe read granted, reset=0 before the next edge -> pipe_rvalid stays 0, vga_wait and stall_count read 0 after release.
- Saturation: hold conflict with MAX_WAIT=1 for 131072 cycles -> stall_count=16'hFFFF and holds.
